// File: rtl/coin_pkg.sv
// Shared coin encodings, debounce state type and default sizing for the
// coin acceptor.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    NICKLE    = 2'd1,
    DIME      = 2'd2,
    QUARTER   = 2'd3
  } coin_t;

  typedef enum logic [1:0] {
    IDLE,
    RISE_WAIT,
    HIGH,
    FALL_WAIT
  } deb_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_FIFO_DEPTH      = 4;

endpackage

// File: rtl/coin_debounce.sv
// One coin chute: 2-flop synchronizer feeding a debounce FSM that raises a
// single-cycle event on each accepted rising level.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic coin_event
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       meta;
  logic       level;
  deb_state_t state;
  deb_state_t state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      level <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      meta  <= raw;
      level <= meta;
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    coin_event = 1'b0;
    case (state)
      IDLE: begin
        if (level) begin
          state_next = RISE_WAIT;
          cnt_next   = '0;
        end
      end
      RISE_WAIT: begin
        if (!level) begin
          state_next = IDLE;
        end else if (cnt == LAST) begin
          state_next = HIGH;
          coin_event = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      HIGH: begin
        if (!level) begin
          state_next = FALL_WAIT;
          cnt_next   = '0;
        end
      end
      FALL_WAIT: begin
        if (level) begin
          state_next = HIGH;
        end else if (cnt == LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/coin_acceptor.sv
// Three debounced coin chutes arbitrated into an in-order coin FIFO that
// is drained one coin per cycle whenever the vending FSM is ready.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_nickle_raw,
  input  logic                          i_dime_raw,
  input  logic                          i_quarter_raw,
  input  logic                          i_ready,
  output logic                          o_nickle,
  output logic                          o_dime,
  output logic                          o_quarter,
  output logic                          o_reject,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  typedef logic [PW:0] count_t;
  localparam count_t FULL_COUNT = count_t'(FIFO_DEPTH);

  logic [2:0]    ev;  // {quarter, dime, nickel}
  coin_t         ev_coin;
  coin_t         head;
  logic          single;
  logic          multi;
  logic          pop;
  logic          push;
  logic          reject;
  coin_t         mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickle (
    .clk(i_clk), .rst(i_rst), .raw(i_nickle_raw), .coin_event(ev[0])
  );
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
    .clk(i_clk), .rst(i_rst), .raw(i_dime_raw), .coin_event(ev[1])
  );
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_quarter (
    .clk(i_clk), .rst(i_rst), .raw(i_quarter_raw), .coin_event(ev[2])
  );

  always_comb begin
    ev_coin = COIN_NONE;
    case (ev)
      3'b001:  ev_coin = NICKLE;
      3'b010:  ev_coin = DIME;
      3'b100:  ev_coin = QUARTER;
      default: ev_coin = COIN_NONE;
    endcase
  end

  // Simultaneous events indicate a chute fault and are all discarded.
  assign multi  = (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);
  assign single = (ev_coin != COIN_NONE);
  assign o_full = (o_count == FULL_COUNT);
  assign pop    = (o_count != '0) && i_ready;
  assign push   = single && (!o_full || pop);
  assign reject = multi || (single && o_full && !pop);
  assign head   = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone decide
  // which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= ev_coin;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_count   <= '0;
      o_nickle  <= 1'b0;
      o_dime    <= 1'b0;
      o_quarter <= 1'b0;
      o_reject  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
      o_nickle  <= pop && (head == NICKLE);
      o_dime    <= pop && (head == DIME);
      o_quarter <= pop && (head == QUARTER);
      o_reject  <= reject;
    end
  end

endmodule
